// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if
//
// Purpose: bundles everything that passes between one sprite motion
// controller and its surroundings. The keyboard strobe, the scan code and the
// four wall-collision flags come in. The sprite position, direction, motion
// status and step pulse go out to the VGA controller.
//
// Signals:
//   ps2_key_pressed   one-cycle strobe, ps2_key_data_in valid this cycle
//   ps2_key_data_in   PS/2 scan-code byte
//   collisionUp/Down/Right/Left  wall adjacent to the sprite in that direction
//   player_x          sprite x (zero-extended 10-bit value)
//   player_y          sprite y (zero-extended 9-bit value)
//   player_direction  00 right, 01 down, 10 left, 11 up
//   moving            high while the sprite is travelling
//   step_tick         one-cycle pulse marking each movement step
//
// Modports:
//   master  drives keys and collisions, observes the sprite
//   slave   the motion controller itself
interface player_motion_ctrl_if;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data_in;
  logic        collisionUp;
  logic        collisionDown;
  logic        collisionRight;
  logic        collisionLeft;
  logic [31:0] player_x;
  logic [31:0] player_y;
  logic [1:0]  player_direction;
  logic        moving;
  logic        step_tick;

  modport master (
    output ps2_key_pressed, ps2_key_data_in,
    output collisionUp, collisionDown, collisionRight, collisionLeft,
    input  player_x, player_y, player_direction, moving, step_tick
  );

  modport slave (
    input  ps2_key_pressed, ps2_key_data_in,
    input  collisionUp, collisionDown, collisionRight, collisionLeft,
    output player_x, player_y, player_direction, moving, step_tick
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
//
// Purpose: moves one sprite across the 640x480 playfield. The direction comes
// from PS/2 make codes, and walls block movement through the per-direction
// collision flags from the VGA controller. A free-running divider produces
// the movement step. On each step the sprite takes a buffered turn if that
// turn is clear. Otherwise it keeps going straight if possible, and stops
// when it is blocked.
//
// Ports:
//   procClock  the only clock
//   reset      synchronous, active-high
//   bus        player_motion_ctrl_if.slave (keys and collisions in, sprite out)
module player_motion_ctrl #(
  parameter int         STEP_DIV  = 250000,
  parameter int         X_INIT    = 32,
  parameter int         Y_INIT    = 32,
  parameter int         X_MAX     = 616,
  parameter int         Y_MAX     = 456,
  parameter logic [7:0] KEY_UP    = 8'h1D,
  parameter logic [7:0] KEY_DOWN  = 8'h1B,
  parameter logic [7:0] KEY_LEFT  = 8'h1C,
  parameter logic [7:0] KEY_RIGHT = 8'h23
) (
  input logic                  procClock,
  input logic                  reset,
  player_motion_ctrl_if.slave  bus
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  localparam logic [9:0] X_INIT_C = 10'(X_INIT);
  localparam logic [8:0] Y_INIT_C = 9'(Y_INIT);
  localparam logic [9:0] X_MAX_C  = 10'(X_MAX);
  localparam logic [8:0] Y_MAX_C  = 9'(Y_MAX);

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic {ST_STOPPED, ST_MOVING} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic [9:0]       r_x;
  logic [8:0]       r_y;
  logic [1:0]       r_dir;
  logic             r_moving;
  logic [1:0]       r_reqDir;
  logic             r_reqValid;
  logic             r_breakPending;

  logic             w_keyHit;
  logic [1:0]       w_keyDir;
  logic             w_blockedReq;
  logic             w_blockedCur;

  // A direction is blocked by a wall flag or by the playfield edge. The edge
  // check is what keeps the position from ever wrapping around.
  function automatic logic isBlocked(input logic [1:0] d, input logic [9:0] x,
                                     input logic [8:0] y);
    case (d)
      DIR_RIGHT: isBlocked = bus.collisionRight || (x == X_MAX_C);
      DIR_DOWN:  isBlocked = bus.collisionDown  || (y == Y_MAX_C);
      DIR_LEFT:  isBlocked = bus.collisionLeft  || (x == 10'd0);
      default:   isBlocked = bus.collisionUp    || (y == 9'd0);
    endcase
  endfunction

  function automatic logic [9:0] stepX(input logic [1:0] d, input logic [9:0] x);
    case (d)
      DIR_RIGHT: stepX = x + 10'd1;
      DIR_LEFT:  stepX = x - 10'd1;
      default:   stepX = x;
    endcase
  endfunction

  function automatic logic [8:0] stepY(input logic [1:0] d, input logic [8:0] y);
    case (d)
      DIR_DOWN: stepY = y + 9'd1;
      DIR_UP:   stepY = y - 9'd1;
      default:  stepY = y;
    endcase
  endfunction

  assign w_blockedReq = isBlocked(r_reqDir, r_x, r_y);
  assign w_blockedCur = isBlocked(r_dir, r_x, r_y);

  // Map a make code to a direction code.
  always_comb begin
    w_keyHit = 1'b1;
    w_keyDir = DIR_RIGHT;
    case (bus.ps2_key_data_in)
      KEY_RIGHT: w_keyDir = DIR_RIGHT;
      KEY_DOWN:  w_keyDir = DIR_DOWN;
      KEY_LEFT:  w_keyDir = DIR_LEFT;
      KEY_UP:    w_keyDir = DIR_UP;
      default:   w_keyHit = 1'b0;
    endcase
  end

  // The step divider. The tick is registered, so it is high for the cycle
  // that follows the counter's terminal value.
  always_ff @(posedge procClock) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_LAST);
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  // The motion FSM and the key decoder. The decoder is written after the FSM,
  // so a key arriving on a tick edge re-arms the request even when that tick
  // consumes the old one.
  always_ff @(posedge procClock) begin
    if (reset) begin
      r_state        <= ST_STOPPED;
      r_x            <= X_INIT_C;
      r_y            <= Y_INIT_C;
      r_dir          <= DIR_RIGHT;
      r_moving       <= 1'b0;
      r_reqDir       <= DIR_RIGHT;
      r_reqValid     <= 1'b0;
      r_breakPending <= 1'b0;
    end else begin
      if (r_tick) begin
        if (r_reqValid && !w_blockedReq) begin
          r_dir      <= r_reqDir;
          r_x        <= stepX(r_reqDir, r_x);
          r_y        <= stepY(r_reqDir, r_y);
          r_reqValid <= 1'b0;
          r_state    <= ST_MOVING;
          r_moving   <= 1'b1;
        end else if (r_state == ST_MOVING) begin
          if (!w_blockedCur) begin
            r_x <= stepX(r_dir, r_x);
            r_y <= stepY(r_dir, r_y);
          end else begin
            r_state  <= ST_STOPPED;
            r_moving <= 1'b0;
          end
        end
      end

      // After a break prefix, the next byte is the released key and is
      // thrown away. The extended prefix E0 leaves the break flag untouched.
      if (bus.ps2_key_pressed) begin
        if (r_breakPending) begin
          r_breakPending <= 1'b0;
        end else if (bus.ps2_key_data_in == 8'hF0) begin
          r_breakPending <= 1'b1;
        end else if (w_keyHit && (bus.ps2_key_data_in != 8'hE0)) begin
          r_reqDir   <= w_keyDir;
          r_reqValid <= 1'b1;
        end
      end
    end
  end

  assign bus.player_x         = {22'd0, r_x};
  assign bus.player_y         = {23'd0, r_y};
  assign bus.player_direction = r_dir;
  assign bus.moving           = r_moving;
  assign bus.step_tick        = r_tick;

endmodule
